// File: rtl/pp_pkg.sv
// Shared types for the ping-pong buffer write path: per-bank fill state and
// the default lane-array shape of one projection beat.
package pp_pkg;

  typedef enum logic [1:0] {PP_EMPTY, PP_FILLING, PP_FULL} pp_bank_state_t;

  localparam int PP_IN_WIDTH      = 32;
  localparam int PP_TOTAL_INPUT_W = 4;

  typedef logic [PP_TOTAL_INPUT_W-1:0][PP_IN_WIDTH-1:0] pp_lanes_t;

endpackage

// File: rtl/pp_bank_writer_if.sv
// Producer stream, consumer release/full handshake and per-bank port-A strobes
// between the projection stage, the bank writer and the ping-pong buffer.
interface pp_bank_writer_if #(
  parameter int IN_WIDTH      = 32,
  parameter int TOTAL_INPUT_W = 4,
  parameter int ADDR_WIDTH    = 8
);

  logic                                    in_valid;
  logic                                    in_ready;
  logic [TOTAL_INPUT_W-1:0][IN_WIDTH-1:0]  in_data;
  logic                                    bank0_ena;
  logic                                    bank1_ena;
  logic                                    bank0_wea;
  logic                                    bank1_wea;
  logic [ADDR_WIDTH-1:0]                   bank0_addra;
  logic [ADDR_WIDTH-1:0]                   bank1_addra;
  logic [TOTAL_INPUT_W-1:0][IN_WIDTH-1:0]  bank0_din;
  logic [TOTAL_INPUT_W-1:0][IN_WIDTH-1:0]  bank1_din;
  logic [1:0]                              bank_full;
  logic [1:0]                              bank_release;
  logic                                    wr_bank;
  logic                                    err_release;

  modport master (
    output in_valid, in_data, bank_release,
    input  in_ready, bank0_ena, bank1_ena, bank0_wea, bank1_wea,
           bank0_addra, bank1_addra, bank0_din, bank1_din,
           bank_full, wr_bank, err_release
  );

  modport slave (
    input  in_valid, in_data, bank_release,
    output in_ready, bank0_ena, bank1_ena, bank0_wea, bank1_wea,
           bank0_addra, bank1_addra, bank0_din, bank1_din,
           bank_full, wr_bank, err_release
  );

endinterface

// File: rtl/pp_bank_tracker.sv
// Fill-state tracker for one ping-pong bank: EMPTY -> FILLING -> FULL -> EMPTY,
// with a sticky error for releases that arrive while the bank is not FULL.
module pp_bank_tracker
  import pp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fill_start_i,
  input  logic fill_done_i,
  input  logic release_i,
  output logic full_o,
  output logic err_o
);

  pp_bank_state_t state_q, state_d;
  logic           err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PP_EMPTY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Writes never target a FULL bank, so a release can only collide with a fill
  // when it is itself illegal; that case keeps the fill and only flags the error.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      PP_EMPTY:   if (fill_start_i) state_d = PP_FILLING;
      PP_FILLING: if (fill_done_i)  state_d = PP_FULL;
      PP_FULL:    if (release_i)    state_d = PP_EMPTY;
      default:                      state_d = PP_EMPTY;
    endcase
    if (release_i && state_q != PP_FULL) err_d = 1'b1;
  end

  assign full_o = (state_q == PP_FULL);
  assign err_o  = err_q;

endmodule

// File: rtl/pp_bank_writer.sv
// Write-side sequencer for a ping-pong buffer: turns a valid/ready beat stream
// into registered per-bank port-A strobes, alternating banks one fill at a time.
module pp_bank_writer
  import pp_pkg::*;
#(
  parameter int IN_WIDTH      = PP_IN_WIDTH,
  parameter int TOTAL_INPUT_W = PP_TOTAL_INPUT_W,
  parameter int ADDR_WIDTH    = 8,
  parameter int TOTAL_DEPTH   = 12
) (
  input logic            clk,
  input logic            rst,
  pp_bank_writer_if.slave bus
);

  typedef logic [TOTAL_INPUT_W-1:0][IN_WIDTH-1:0] lanes_t;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(TOTAL_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            ena_q, ena_d;
  logic [ADDR_WIDTH-1:0] addr_q [2];
  logic [ADDR_WIDTH-1:0] addr_d [2];
  lanes_t                din_q [2];
  lanes_t                din_d [2];

  logic [1:0] full, err, fill_start, fill_done;
  logic       in_ready, fire, last_beat;

  assign in_ready  = !rst && !full[wr_bank_q];
  assign fire      = bus.in_valid && in_ready;
  assign last_beat = (wr_ptr_q == LastAddr);

  // Address/data hold their last value between strobes; only ena pulses.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_bank_d  = wr_bank_q;
    ena_d      = 2'b00;
    fill_start = 2'b00;
    fill_done  = 2'b00;
    for (int b = 0; b < 2; b++) begin
      addr_d[b] = addr_q[b];
      din_d[b]  = din_q[b];
    end
    if (fire) begin
      ena_d[wr_bank_q]      = 1'b1;
      addr_d[wr_bank_q]     = wr_ptr_q;
      din_d[wr_bank_q]      = bus.in_data;
      fill_start[wr_bank_q] = (wr_ptr_q == '0);
      fill_done[wr_bank_q]  = last_beat;
      if (last_beat) begin
        wr_ptr_d  = '0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      ena_q     <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        addr_q[b] <= '0;
        din_q[b]  <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      ena_q     <= ena_d;
      for (int b = 0; b < 2; b++) begin
        addr_q[b] <= addr_d[b];
        din_q[b]  <= din_d[b];
      end
    end
  end

  pp_bank_tracker u_trk0 (
    .clk          (clk),
    .rst          (rst),
    .fill_start_i (fill_start[0]),
    .fill_done_i  (fill_done[0]),
    .release_i    (bus.bank_release[0]),
    .full_o       (full[0]),
    .err_o        (err[0])
  );

  pp_bank_tracker u_trk1 (
    .clk          (clk),
    .rst          (rst),
    .fill_start_i (fill_start[1]),
    .fill_done_i  (fill_done[1]),
    .release_i    (bus.bank_release[1]),
    .full_o       (full[1]),
    .err_o        (err[1])
  );

  assign bus.in_ready    = in_ready;
  assign bus.bank0_ena   = ena_q[0];
  assign bus.bank1_ena   = ena_q[1];
  assign bus.bank0_wea   = ena_q[0];
  assign bus.bank1_wea   = ena_q[1];
  assign bus.bank0_addra = addr_q[0];
  assign bus.bank1_addra = addr_q[1];
  assign bus.bank0_din   = din_q[0];
  assign bus.bank1_din   = din_q[1];
  assign bus.bank_full   = full;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.err_release = |err;

endmodule

// File: tb/tb_pp_bank_writer.sv
// Bench for pp_bank_writer: a fill-count model of both banks checked every
// cycle, directed scenarios with literal expectations, then a random phase.
module tb_pp_bank_writer;

  localparam int IW    = 32;
  localparam int LANES = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 12;
  localparam int DW    = IW * LANES;

  typedef logic [LANES-1:0][IW-1:0] lanes_t;

  logic clk;
  logic rst;

  pp_bank_writer_if #(.IN_WIDTH(IW), .TOTAL_INPUT_W(LANES), .ADDR_WIDTH(AW)) bus ();

  pp_bank_writer #(
    .IN_WIDTH      (IW),
    .TOTAL_INPUT_W (LANES),
    .ADDR_WIDTH    (AW),
    .TOTAL_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Each lane carries the beat number plus its lane index so lane swaps show up.
  function automatic lanes_t mkData(input int n);
    lanes_t d;
    for (int k = 0; k < LANES; k++) d[k] = IW'(n * 16 + k);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Behavioural model: each bank is a fill count plus a full flag; the writer
  // pours beats into mBank and moves to the other bank once DEPTH are in.
  int            mCnt;
  logic [1:0]    mFull;
  logic [1:0]    mFullNext;
  logic          mBank;
  logic          mErr;
  logic          mFire;
  logic [1:0]    eEna;
  logic [AW-1:0] eAddr [2];
  lanes_t        eDin  [2];

  always @(posedge clk) begin
    if (rst) begin
      mCnt  = 0;
      mFull = 2'b00;
      mBank = 1'b0;
      mErr  = 1'b0;
      eEna  = 2'b00;
      for (int b = 0; b < 2; b++) begin
        eAddr[b] = '0;
        eDin[b]  = '0;
      end
    end else begin
      mFire = bus.in_valid && !mFull[mBank];
      eEna  = 2'b00;
      if (mFire) begin
        eEna[mBank]  = 1'b1;
        eAddr[mBank] = AW'(mCnt);
        eDin[mBank]  = bus.in_data;
      end
      mFullNext = mFull;
      for (int b = 0; b < 2; b++)
        if (bus.bank_release[b]) begin
          if (mFull[b]) mFullNext[b] = 1'b0;
          else          mErr = 1'b1;
        end
      if (mFire) begin
        mCnt++;
        if (mCnt == DEPTH) begin
          mCnt            = 0;
          mFullNext[mBank] = 1'b1;
          mBank           = !mBank;
        end
      end
      mFull = mFullNext;
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready",    bus.in_ready,    (!rst && !mFull[mBank]));
    checkOutput("bank0_ena",   bus.bank0_ena,   eEna[0]);
    checkOutput("bank1_ena",   bus.bank1_ena,   eEna[1]);
    checkOutput("bank0_wea",   bus.bank0_wea,   eEna[0]);
    checkOutput("bank1_wea",   bus.bank1_wea,   eEna[1]);
    checkOutput("bank0_addra", bus.bank0_addra, eAddr[0]);
    checkOutput("bank1_addra", bus.bank1_addra, eAddr[1]);
    checkOutput("bank0_din",   bus.bank0_din,   eDin[0]);
    checkOutput("bank1_din",   bus.bank1_din,   eDin[1]);
    checkOutput("bank_full",   bus.bank_full,   mFull);
    checkOutput("wr_bank",     bus.wr_bank,     mBank);
    checkOutput("err_release", bus.err_release, mErr);
  end

  // Drive one cycle of inputs, return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic v, input int n, input logic [1:0] rel);
    bus.in_valid     = v;
    bus.in_data      = mkData(n);
    bus.bank_release = rel;
    @(posedge clk);
    #1;
    bus.bank_release = 2'b00;
  endtask

  // Hold a beat until accepted; rel is pulsed only in the first cycle.
  task automatic sendBeat(input int n, input logic [1:0] rel);
    int   waited;
    logic took;
    waited = 0;
    bus.in_valid     = 1'b1;
    bus.in_data      = mkData(n);
    bus.bank_release = rel;
    do begin
      took = bus.in_ready;
      @(posedge clk);
      #1;
      bus.bank_release = 2'b00;
      waited++;
    end while (!took && waited < 200);
    bus.in_valid = 1'b0;
    if (!took) begin
      nChecks++;
      $display("[TB] FAIL beat_accept_timeout beat=%0d actual=stalled required=accepted", n);
    end
  endtask

  int   seq;
  logic v;
  logic took;

  initial begin
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.bank_release = 2'b00;
    seq              = 0;

    $display("[TB] reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready",  bus.in_ready,    1'b0);
    checkOutput("rst_bank_full", bus.bank_full,   2'b00);
    checkOutput("rst_ena0",      bus.bank0_ena,   1'b0);
    checkOutput("rst_addr0",     bus.bank0_addra, 8'd0);
    checkOutput("rst_wr_bank",   bus.wr_bank,     1'b0);
    checkOutput("rst_err",       bus.err_release, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", bus.in_ready, 1'b1);

    $display("[TB] fill bank 0 back to back");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, seq + i, 2'b00);
    seq += DEPTH;
    checkOutput("fill0_last_ena",  bus.bank0_ena,   1'b1);
    checkOutput("fill0_last_addr", bus.bank0_addra, 8'd11);
    checkOutput("fill0_last_din",  bus.bank0_din,   mkData(11));
    checkOutput("fill0_full",      bus.bank_full,   2'b01);
    checkOutput("fill0_wr_bank",   bus.wr_bank,     1'b1);
    applyStimulus(1'b0, 0, 2'b00);

    $display("[TB] fill bank 1 then stall");
    for (int i = 0; i < DEPTH; i++) sendBeat(seq + i, 2'b00);
    seq += DEPTH;
    checkOutput("both_full",      bus.bank_full, 2'b11);
    checkOutput("both_wr_bank",   bus.wr_bank,   1'b0);
    applyStimulus(1'b1, seq, 2'b00);
    checkOutput("stall_in_ready", bus.in_ready,  1'b0);
    applyStimulus(1'b1, seq, 2'b00);
    checkOutput("stall_no_ena",   bus.bank0_ena, 1'b0);
    applyStimulus(1'b1, seq, 2'b01);
    checkOutput("release_in_ready", bus.in_ready,  1'b1);
    checkOutput("release_full",     bus.bank_full, 2'b10);
    sendBeat(seq, 2'b00);
    seq++;
    checkOutput("resume_ena0",  bus.bank0_ena,   1'b1);
    checkOutput("resume_addr0", bus.bank0_addra, 8'd0);
    checkOutput("resume_din0",  bus.bank0_din,   mkData(24));

    $display("[TB] release in the same cycle as a final beat");
    applyStimulus(1'b0, 0, 2'b10);
    for (int i = 1; i < DEPTH; i++) sendBeat(seq++, 2'b00);
    checkOutput("sim_pre_full", bus.bank_full, 2'b01);
    for (int i = 0; i < DEPTH - 1; i++) sendBeat(seq++, 2'b00);
    sendBeat(seq++, 2'b01);
    checkOutput("sim_full",     bus.bank_full,   2'b10);
    checkOutput("sim_in_ready", bus.in_ready,    1'b1);
    checkOutput("sim_ena1",     bus.bank1_ena,   1'b1);
    checkOutput("sim_addr1",    bus.bank1_addra, 8'd11);

    $display("[TB] release of an empty bank");
    applyStimulus(1'b0, 0, 2'b10);
    checkOutput("legal_rel_err",  bus.err_release, 1'b0);
    applyStimulus(1'b0, 0, 2'b10);
    checkOutput("bad_rel_err",    bus.err_release, 1'b1);
    checkOutput("bad_rel_full",   bus.bank_full,   2'b00);
    applyStimulus(1'b0, 0, 2'b00);
    checkOutput("bad_rel_sticky", bus.err_release, 1'b1);

    $display("[TB] reset mid fill");
    for (int i = 0; i < 5; i++) sendBeat(seq++, 2'b00);
    rst = 1'b1;
    applyStimulus(1'b1, seq, 2'b00);
    checkOutput("midrst_ena0",     bus.bank0_ena,   1'b0);
    checkOutput("midrst_addr0",    bus.bank0_addra, 8'd0);
    checkOutput("midrst_err",      bus.err_release, 1'b0);
    checkOutput("midrst_in_ready", bus.in_ready,    1'b0);
    rst = 1'b0;
    #1;
    sendBeat(seq, 2'b00);
    seq++;
    checkOutput("refill_ena0",  bus.bank0_ena,   1'b1);
    checkOutput("refill_addr0", bus.bank0_addra, 8'd0);
    checkOutput("refill_bank",  bus.wr_bank,     1'b0);

    $display("[TB] random valid with periodic releases");
    for (int cyc = 0; cyc < 450; cyc++) begin
      v    = 1'($urandom_range(0, 1));
      took = bus.in_ready;
      applyStimulus(v, seq, (cyc % 30 == 29) ? mFull : 2'b00);
      if (v && took) seq++;
    end
    applyStimulus(1'b0, 0, 2'b00);
    applyStimulus(1'b0, 0, 2'b00);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
